// File: rtl/uart_pkg.sv
// uart_pkg: register offsets, STATUS bit positions and FSM state types for uart_core.
package uart_pkg;
  localparam logic [2:0] REG_TXDATA  = 3'd0;
  localparam logic [2:0] REG_RXDATA  = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_CTRL    = 3'd3;
  localparam logic [2:0] REG_BAUDDIV = 3'd4;
  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_FULL   = 2;
  localparam int ST_RX_EMPTY  = 3;
  localparam int ST_OVERRUN   = 4;
  localparam int ST_FRAME_ERR = 5;
  localparam int ST_TX_BUSY   = 6;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; pushes when full and pops when empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = wptr == rptr;
  assign rdata   = mem[rptr[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/uart_core.sv
// uart_core: UART register bank, TX/RX FIFOs, baud tick, 8N1 transmitter and 16x receiver.
module uart_core
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_RESET  = 651
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4:0]            addr,
  input  logic                  we,
  input  logic                  en,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  input  logic                  rx,
  output logic                  tx
);
  logic [2:0] sel;
  logic wr, rd_c, wr_status, wr_ctrl, wr_baud;
  logic [1:0] ctrl;
  logic [15:0] baud_div, div_cnt;
  logic tick;
  logic overrun, frame_err, ovr_set, ferr_set;
  logic tx_push, tx_pop, tx_full, tx_empty;
  logic rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] tx_rdata, rx_rdata;
  logic [6:0] status;
  logic unused;
  tx_state_e tx_st, tx_st_n;
  logic [3:0] tcnt, tcnt_n;
  logic [2:0] tbit, tbit_n;
  logic [7:0] tsh, tsh_n;
  rx_state_e rx_st, rx_st_n;
  logic [3:0] rcnt, rcnt_n;
  logic [2:0] rbit, rbit_n;
  logic [7:0] rsh, rsh_n;
  logic rx_s1, rx_s;
  assign unused    = ^{addr[1:0], wdata[DATA_WIDTH-1:16]};
  assign sel       = addr[4:2];
  assign wr        = en & rd & we;
  assign rd_c      = en & rd & ~we;
  assign wr_status = wr && sel == REG_STATUS;
  assign wr_ctrl   = wr && sel == REG_CTRL;
  assign wr_baud   = wr && sel == REG_BAUDDIV;
  assign tx_push   = wr && sel == REG_TXDATA;
  assign rx_pop    = rd_c && sel == REG_RXDATA;
  assign tick      = div_cnt == '0;
  assign status    = {tx_st != TX_IDLE, frame_err, overrun, rx_empty, rx_full, tx_empty, tx_full};
  assign rdata     = sel == REG_RXDATA  ? (rx_empty ? '0 : DATA_WIDTH'({1'b1, rx_rdata})) :
                     sel == REG_STATUS  ? DATA_WIDTH'(status) :
                     sel == REG_CTRL    ? DATA_WIDTH'(ctrl) :
                     sel == REG_BAUDDIV ? DATA_WIDTH'(baud_div) : '0;
  assign tx        = tx_st == TX_START ? 1'b0 : tx_st == TX_DATA ? tsh[0] : 1'b1;
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .wdata(wdata[7:0]),
    .rdata(tx_rdata), .full(tx_full), .empty(tx_empty)
  );
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .wdata(rsh),
    .rdata(rx_rdata), .full(rx_full), .empty(rx_empty)
  );
  // Error set terms take priority over a simultaneous write-1-to-clear.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ctrl      <= 2'b11;
      baud_div  <= 16'(DIV_RESET);
      div_cnt   <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
      rx_s1     <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      if (wr_ctrl) ctrl <= wdata[1:0];
      if (wr_baud) baud_div <= wdata[15:0];
      div_cnt   <= wr_baud ? wdata[15:0] : tick ? baud_div : div_cnt - 1'b1;
      overrun   <= ovr_set | (overrun & ~(wr_status & wdata[ST_OVERRUN]));
      frame_err <= ferr_set | (frame_err & ~(wr_status & wdata[ST_FRAME_ERR]));
      rx_s1     <= rx;
      rx_s      <= rx_s1;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tx_st <= TX_IDLE;
      tcnt  <= '0;
      tbit  <= '0;
      tsh   <= '0;
      rx_st <= RX_IDLE;
      rcnt  <= '0;
      rbit  <= '0;
      rsh   <= '0;
    end else begin
      tx_st <= tx_st_n;
      tcnt  <= tcnt_n;
      tbit  <= tbit_n;
      tsh   <= tsh_n;
      rx_st <= rx_st_n;
      rcnt  <= rcnt_n;
      rbit  <= rbit_n;
      rsh   <= rsh_n;
    end
  // Every TX state lasts 16 ticks; the 4-bit counter wraps back to 0 on each transition.
  always_comb begin
    tx_st_n = tx_st;
    tcnt_n  = tcnt;
    tbit_n  = tbit;
    tsh_n   = tsh;
    tx_pop  = 1'b0;
    if (tick)
      case (tx_st)
        TX_IDLE:
          if (ctrl[0] && !tx_empty) begin
            tx_st_n = TX_START;
            tx_pop  = 1'b1;
            tsh_n   = tx_rdata;
            tcnt_n  = '0;
          end
        TX_START: begin
          tcnt_n = tcnt + 1'b1;
          if (tcnt == 4'd15) begin
            tx_st_n = TX_DATA;
            tbit_n  = '0;
          end
        end
        TX_DATA: begin
          tcnt_n = tcnt + 1'b1;
          if (tcnt == 4'd15) begin
            tsh_n  = tsh >> 1;
            tbit_n = tbit + 1'b1;
            if (tbit == 3'd7) tx_st_n = TX_STOP;
          end
        end
        default: begin
          tcnt_n = tcnt + 1'b1;
          if (tcnt == 4'd15) tx_st_n = TX_IDLE;
        end
      endcase
  end
  // The start edge is seen on any clk; all later samples land on ticks near mid-bit.
  always_comb begin
    rx_st_n  = rx_st;
    rcnt_n   = rcnt;
    rbit_n   = rbit;
    rsh_n    = rsh;
    rx_push  = 1'b0;
    ovr_set  = 1'b0;
    ferr_set = 1'b0;
    if (!ctrl[1]) rx_st_n = RX_IDLE;
    else
      case (rx_st)
        RX_IDLE:
          if (!rx_s) begin
            rx_st_n = RX_START;
            rcnt_n  = '0;
          end
        RX_START:
          if (tick) begin
            rcnt_n = rcnt + 1'b1;
            if (rcnt == 4'd7) begin
              rx_st_n = rx_s ? RX_IDLE : RX_DATA;
              rcnt_n  = '0;
              rbit_n  = '0;
            end
          end
        RX_DATA:
          if (tick) begin
            rcnt_n = rcnt + 1'b1;
            if (rcnt == 4'd15) begin
              rsh_n  = {rx_s, rsh[7:1]};
              rbit_n = rbit + 1'b1;
              if (rbit == 3'd7) rx_st_n = RX_STOP;
            end
          end
        default:
          if (tick) begin
            rcnt_n = rcnt + 1'b1;
            if (rcnt == 4'd15) begin
              rx_st_n  = RX_IDLE;
              rx_push  = rx_s & ~rx_full;
              ovr_set  = rx_s & rx_full;
              ferr_set = ~rx_s;
            end
          end
      endcase
  end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: scenario tasks with queue scoreboards for TX frames and RX bytes.
module tb_uart_core;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int DIVR = 651;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic we = 1'b0, en = 1'b0, rd = 1'b0, rx = 1'b1;
  logic [4:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic tx;
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  always #5 clk = ~clk;

  uart_core #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_RESET(DIVR)) dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .en(en), .rd(rd),
    .wdata(wdata), .rdata(rdata), .rx(rx), .tx(tx)
  );

  task automatic bus_write(input logic [4:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    en = 1'b1; rd = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    en = 1'b0; rd = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [DW-1:0] d);
    @(negedge clk);
    en = 1'b1; rd = 1'b1; we = 1'b0; addr = a;
    #1 d = rdata;
    @(negedge clk);
    en = 1'b0; rd = 1'b0;
  endtask

  // Captures one frame at 64 clk per bit; clean=0 if any bit cell is not constant.
  task automatic get_frame(input int timeout, output bit got, output bit clean, output logic [9:0] bits);
    int t = 0;
    logic seg;
    got = 1'b0; clean = 1'b1; bits = '0; seg = 1'b1;
    @(negedge clk);
    while (tx !== 1'b0 && t < timeout) begin
      @(negedge clk);
      t++;
    end
    if (tx !== 1'b0) return;
    got = 1'b1;
    for (int i = 0; i < 640; i++) begin
      if (i > 0) @(negedge clk);
      if (i % 64 == 0) begin
        seg = tx;
        bits[i/64] = tx;
      end else if (tx !== seg) clean = 1'b0;
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input bit stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    @(negedge clk);
    for (int s = 0; s < 10; s++) begin
      rx = f[s];
      repeat ((s == 9 && !stop) ? 48 : 64) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic test_reset;
    logic [DW-1:0] d;
    repeat (3) @(negedge clk);
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b expected 1", tx); end
    rst = 1'b0;
    bus_read(5'h08, d);
    n_checks++;
    if (d !== 32'h0A) begin n_fail++; $display("FAIL reset_status: got %h expected 0000000a", d); end
    bus_read(5'h0C, d);
    n_checks++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 00000003", d); end
    bus_read(5'h10, d);
    n_checks++;
    if (d !== 32'(DIVR)) begin n_fail++; $display("FAIL reset_baud: got %h expected %h", d, 32'(DIVR)); end
    bus_read(5'h04, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL reset_rxdata: got %h expected 0", d); end
    bus_read(5'h00, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL txdata_read: got %h expected 0", d); end
    bus_read(5'h14, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h expected 0", d); end
  endtask

  task automatic test_tx_frame;
    logic [DW-1:0] d;
    logic [9:0] bits;
    logic [7:0] exp;
    bit got, clean;
    bus_write(5'h10, 32'd3);
    bus_read(5'h10, d);
    n_checks++;
    if (d !== 32'd3) begin n_fail++; $display("FAIL baud_write: got %h expected 3", d); end
    tx_q.push_back(8'hA5);
    bus_write(5'h00, 32'hA5);
    fork
      get_frame(400, got, clean, bits);
      for (int k = 0; k < 3; k++) begin
        repeat (150) @(negedge clk);
        bus_read(5'h08, d);
        n_checks++;
        if (d[6] !== 1'b1) begin n_fail++; $display("FAIL tx_busy_frame: got %b expected 1", d[6]); end
      end
    join
    exp = tx_q.size() > 0 ? tx_q.pop_front() : 8'h00;
    n_checks++;
    if (got !== 1'b1 || clean !== 1'b1) begin n_fail++; $display("FAIL tx_timing: got frame=%b clean=%b expected 1 1", got, clean); end
    n_checks++;
    if (bits !== {1'b1, exp, 1'b0}) begin n_fail++; $display("FAIL tx_bits: got %b expected %b", bits, {1'b1, exp, 1'b0}); end
    repeat (2) @(negedge clk);
    bus_read(5'h08, d);
    n_checks++;
    if ((d & 32'h42) !== 32'h02) begin n_fail++; $display("FAIL tx_idle_after: got %h expected busy=0 empty=1", d); end
  endtask

  task automatic test_rx_frame;
    logic [DW-1:0] d;
    logic [7:0] exp;
    rx_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    repeat (10) @(negedge clk);
    exp = rx_q.size() > 0 ? rx_q.pop_front() : 8'h00;
    bus_read(5'h04, d);
    n_checks++;
    if (d !== {23'b0, 1'b1, exp}) begin n_fail++; $display("FAIL rx_byte: got %h expected %h", d, {23'b0, 1'b1, exp}); end
    bus_read(5'h04, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL rx_empty_read: got %h expected 0", d); end
    bus_read(5'h08, d);
    n_checks++;
    if (d[3] !== 1'b1) begin n_fail++; $display("FAIL rx_empty_flag: got %b expected 1", d[3]); end
  endtask

  task automatic test_tx_fifo_full;
    logic [DW-1:0] d;
    logic [9:0] bits;
    logic [7:0] exp;
    bit got, clean;
    bus_write(5'h0C, 32'h2);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) tx_q.push_back(8'h10 + 8'(i * 7));
      bus_write(5'h00, 32'(8'h10 + 8'(i * 7)));
    end
    bus_read(5'h08, d);
    n_checks++;
    if (d[1:0] !== 2'b01) begin n_fail++; $display("FAIL tx_full_flag: got %b expected 01", d[1:0]); end
    bus_write(5'h0C, 32'h3);
    for (int k = 0; k < 8; k++) begin
      get_frame(400, got, clean, bits);
      exp = tx_q.size() > 0 ? tx_q.pop_front() : 8'h00;
      n_checks++;
      if (got !== 1'b1 || clean !== 1'b1 || bits !== {1'b1, exp, 1'b0}) begin
        n_fail++;
        $display("FAIL tx_fifo_frame%0d: got frame=%b clean=%b bits=%b expected bits=%b", k, got, clean, bits, {1'b1, exp, 1'b0});
      end
    end
    get_frame(1500, got, clean, bits);
    n_checks++;
    if (got !== 1'b0) begin n_fail++; $display("FAIL tx_ninth_dropped: got extra frame %b expected none", bits); end
  endtask

  task automatic test_rx_overrun;
    logic [DW-1:0] d;
    logic [7:0] b, exp;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i < 8) rx_q.push_back(b);
      send_rx(b, 1'b1);
    end
    repeat (10) @(negedge clk);
    bus_read(5'h08, d);
    n_checks++;
    if (d[4:2] !== 3'b101) begin n_fail++; $display("FAIL rx_overrun_flags: got ovr/empty/full=%b expected 101", d[4:2]); end
    for (int k = 0; k < 8; k++) begin
      exp = rx_q.size() > 0 ? rx_q.pop_front() : 8'h00;
      bus_read(5'h04, d);
      n_checks++;
      if (d !== {23'b0, 1'b1, exp}) begin n_fail++; $display("FAIL rx_fifo_byte%0d: got %h expected %h", k, d, {23'b0, 1'b1, exp}); end
    end
    bus_write(5'h08, 32'h10);
    bus_read(5'h08, d);
    n_checks++;
    if (d[4:2] !== 3'b010) begin n_fail++; $display("FAIL rx_overrun_clear: got ovr/empty/full=%b expected 010", d[4:2]); end
  endtask

  task automatic test_frame_err;
    logic [DW-1:0] d;
    send_rx(8'h55, 1'b0);
    repeat (100) @(negedge clk);
    bus_read(5'h08, d);
    n_checks++;
    if (d[5:3] !== 3'b101) begin n_fail++; $display("FAIL frame_err_set: got ferr/ovr/empty=%b expected 101", d[5:3]); end
    bus_write(5'h08, 32'h20);
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    bus_read(5'h08, d);
    n_checks++;
    if (d[5:3] !== 3'b001) begin n_fail++; $display("FAIL glitch_ignored: got ferr/ovr/empty=%b expected 001", d[5:3]); end
    bus_read(5'h04, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL glitch_no_byte: got %h expected 0", d); end
  endtask

  task automatic test_reset_mid_tx;
    logic [DW-1:0] d;
    int t = 0;
    send_rx(8'h5A, 1'b1);
    bus_write(5'h00, 32'h77);
    bus_write(5'h00, 32'h88);
    while (tx !== 1'b0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (tx !== 1'b0) begin n_fail++; $display("FAIL mid_tx_start: got tx=%b expected 0 within 200 clk", tx); end
    repeat (100) @(negedge clk);
    bus_read(5'h08, d);
    n_checks++;
    if (d[6] !== 1'b1 || d[3] !== 1'b0) begin n_fail++; $display("FAIL mid_tx_state: got busy=%b rx_empty=%b expected 1 0", d[6], d[3]); end
    rst = 1'b1;
    #1;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_tx_high: got %b expected 1", tx); end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bus_read(5'h08, d);
    n_checks++;
    if (d !== 32'h0A) begin n_fail++; $display("FAIL rst_status: got %h expected 0000000a", d); end
    bus_read(5'h0C, d);
    n_checks++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL rst_ctrl: got %h expected 3", d); end
    bus_read(5'h10, d);
    n_checks++;
    if (d !== 32'(DIVR)) begin n_fail++; $display("FAIL rst_baud: got %h expected %h", d, 32'(DIVR)); end
  endtask

  initial begin
    test_reset();
    test_tx_frame();
    test_rx_frame();
    test_tx_fifo_full();
    test_rx_overrun();
    test_frame_err();
    test_reset_mid_tx();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
